// File: rtl/key_pkg.sv
// Shared definitions for the key pad scanner, pad model and display decoder.
// Holds matrix geometry, FSM states and snapshot helper functions.
package key_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 5;
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

    typedef logic [4:0] key_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_MULTI
    } key_state_t;

    function automatic logic [4:0] key_count(input logic [NUM_KEYS-1:0] s);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            n = n + {4'd0, s[i]};
        end
        return n;
    endfunction

    // Lowest set bit wins when several keys are down.
    function automatic key_code_t lowest_key(input logic [NUM_KEYS-1:0] s);
        key_code_t k;
        k = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (s[i]) k = key_code_t'(i);
        end
        return k;
    endfunction

endpackage

// File: rtl/key_scanner_if.sv
// Pad-side and display-side signals of the key scanner.
// master is the scanner itself, slave is the pad/display side.
interface key_scanner_if;
    import key_pkg::*;

    logic [NUM_ROWS-1:0] key_row_in;
    logic [NUM_COLS-1:0] key_column_out;
    key_code_t           key_code;
    logic                key_valid;
    logic                key_held;
    logic                key_multi;

    modport master (
        input  key_row_in,
        output key_column_out,
        output key_code,
        output key_valid,
        output key_held,
        output key_multi
    );

    modport slave (
        output key_row_in,
        input  key_column_out,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  key_multi
    );

endinterface

// File: rtl/key_debounce.sv
// Whole-scan debouncer: accepts a snapshot after DEBOUNCE_SCANS identical scans.
// Accept is combinational in the scan-end cycle so the FSM registers on that edge.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] i_snap,
    input  logic                i_scan_end,
    output logic [NUM_KEYS-1:0] o_snap,
    output logic                o_accept
);

    localparam logic [3:0] MAX_CNT = 4'(DEBOUNCE_SCANS);

    logic [NUM_KEYS-1:0] r_prev;
    logic [NUM_KEYS-1:0] r_db;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nx;

    always_comb begin
        w_cnt_nx = 4'd1;
        if (i_snap == r_prev) begin
            w_cnt_nx = (r_cnt >= MAX_CNT) ? MAX_CNT : r_cnt + 4'd1;
        end
    end

    assign o_accept = i_scan_end && (w_cnt_nx == MAX_CNT);
    assign o_snap   = o_accept ? i_snap : r_db;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
            r_db   <= '0;
            r_cnt  <= '0;
        end else if (i_scan_end) begin
            r_prev <= i_snap;
            r_cnt  <= w_cnt_nx;
            if (o_accept) r_db <= i_snap;
        end
    end

endmodule

// File: rtl/key_scanner.sv
// 4x5 key matrix scanner: column rotation, row sync, debounce and report FSM.
// Reports one code per new single-key press with rollover lockout.
module key_scanner
    import key_pkg::*;
#(
    parameter int SCAN_DIV       = 10000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic          clk,
    input  logic          rst,
    key_scanner_if.master bus
);

    localparam int CW  = $clog2(SCAN_DIV);
    localparam int COW = $clog2(NUM_COLS);
    localparam logic [CW-1:0]  LAST_CNT = CW'(SCAN_DIV - 1);
    localparam logic [COW-1:0] LAST_COL = COW'(NUM_COLS - 1);

    logic [CW-1:0]       r_cnt;
    logic [COW-1:0]      r_col;
    logic                r_run;
    logic [NUM_ROWS-1:0] r_sync1;
    logic [NUM_ROWS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_work;

    logic                w_last;
    logic                w_scan_end;
    logic [NUM_KEYS-1:0] w_snap;
    logic [NUM_KEYS-1:0] w_db;
    logic                w_accept;

    assign w_last     = r_run && (r_cnt == LAST_CNT);
    assign w_scan_end = w_last && (r_col == LAST_COL);

    // Full snapshot at scan end includes the column-3 sample taken this cycle.
    always_comb begin
        w_snap = r_work;
        w_snap[NUM_KEYS-1 -: NUM_ROWS] = ~r_sync2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_col   <= '0;
            r_run   <= 1'b0;
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_work  <= '0;
        end else begin
            r_sync1 <= bus.key_row_in;
            r_sync2 <= r_sync1;
            if (!r_run) begin
                r_run <= 1'b1;
            end else if (w_last) begin
                r_cnt <= '0;
                r_col <= r_col + COW'(1);
                r_work[NUM_ROWS*r_col +: NUM_ROWS] <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign bus.key_column_out = r_run ? ~(NUM_COLS'(1) << r_col) : '1;

    key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .i_snap    (w_snap),
        .i_scan_end(w_scan_end),
        .o_snap    (w_db),
        .o_accept  (w_accept)
    );

    key_state_t r_state;
    key_state_t w_state_nx;
    key_code_t  r_code;
    key_code_t  w_code_nx;
    logic       r_valid;
    logic       w_valid_nx;
    logic [4:0] w_n;
    key_code_t  w_low;
    logic       w_none;
    logic       w_one;

    assign w_n    = key_count(w_db);
    assign w_low  = lowest_key(w_db);
    assign w_none = (w_n == 5'd0);
    assign w_one  = (w_n == 5'd1);

    always_comb begin
        w_state_nx = r_state;
        w_code_nx  = r_code;
        w_valid_nx = 1'b0;
        if (w_accept) begin
            unique case (r_state)
                ST_IDLE: begin
                    unique case (1'b1)
                        w_none: w_state_nx = ST_IDLE;
                        w_one: begin
                            w_code_nx  = w_low;
                            w_valid_nx = 1'b1;
                            w_state_nx = ST_PRESSED;
                        end
                        default: w_state_nx = ST_MULTI;
                    endcase
                end
                ST_PRESSED: begin
                    unique case (1'b1)
                        w_none: w_state_nx = ST_IDLE;
                        w_one: begin
                            if (w_low != r_code) begin
                                w_code_nx  = w_low;
                                w_valid_nx = 1'b1;
                            end
                        end
                        default: w_state_nx = ST_MULTI;
                    endcase
                end
                ST_MULTI: begin
                    if (w_none) w_state_nx = ST_IDLE;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_code  <= w_code_nx;
            r_valid <= w_valid_nx;
        end
    end

    assign bus.key_code  = r_code;
    assign bus.key_valid = r_valid;
    assign bus.key_held  = (r_state == ST_PRESSED);
    assign bus.key_multi = (r_state == ST_MULTI);

endmodule

// File: tb/tb_key_scanner.sv
// Bench for key_scanner with a registered key pad model and a pulse scoreboard.
// key_v: 1-20 one key, 21-24 rows 0 and 4 of column key_v-21, else no key.
module tb_key_scanner;
    import key_pkg::*;

    logic clk;
    logic rst;
    int   key_v;

    key_scanner_if kif ();

    key_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(kif.master)
    );

    int        n_checks;
    int        n_errors;
    int        n_pulses;
    key_code_t exp_q[$];
    logic      prev_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NUM_KEYS-1:0] pad_keys(input int v);
        logic [NUM_KEYS-1:0] k;
        k = '0;
        if (v >= 1 && v <= 20) begin
            k[v-1] = 1'b1;
        end else if (v >= 21 && v <= 24) begin
            k[5*(v-21)]     = 1'b1;
            k[5*(v-21) + 4] = 1'b1;
        end
        return k;
    endfunction

    // Pad model: registered, active-low rows for the driven column.
    logic [NUM_KEYS-1:0] pad_k;
    logic [NUM_ROWS-1:0] pad_rows;
    initial kif.key_row_in = '1;
    always @(posedge clk) begin
        pad_k    = pad_keys(key_v);
        pad_rows = '1;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (!kif.key_column_out[c] && pad_k[5*c + r]) pad_rows[r] = 1'b0;
            end
        end
        kif.key_row_in <= pad_rows;
    end

    // Monitor: every key_valid pulse pops the scoreboard.
    initial prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst && kif.key_valid) begin
            n_pulses++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse: got code %0d, expected no pulse",
                         kif.key_code);
            end else begin
                key_code_t e;
                e = exp_q.pop_front();
                if (kif.key_code !== e) begin
                    n_errors++;
                    $display("FAIL pulse_code: got %0d, expected %0d", kif.key_code, e);
                end
            end
            n_checks++;
            if (kif.key_held !== 1'b1 || prev_valid) begin
                n_errors++;
                $display("FAIL pulse_shape: held=%0b prev_valid=%0b, expected 1/0",
                         kif.key_held, prev_valid);
            end
        end
        prev_valid = kif.key_valid;
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_scan_start();
        int n;
        n = 0;
        while (kif.key_column_out == 4'b1110 && n < 100) begin
            tick();
            n++;
        end
        while (kif.key_column_out != 4'b1110 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL scan_timeout: got col %b, expected 1110", kif.key_column_out);
        end
    endtask

    task automatic scans(input int n);
        for (int i = 0; i < n; i++) wait_scan_start();
    endtask

    task automatic chk_levels(input string name, input int code, input int held,
                              input int multi);
        chk({name, "_code"}, int'(kif.key_code), code);
        chk({name, "_held"}, int'(kif.key_held), held);
        chk({name, "_multi"}, int'(kif.key_multi), multi);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        n_checks = 0;
        n_errors = 0;
        n_pulses = 0;
        key_v    = 0;
        rst      = 1'b1;
        repeat (3) tick();
        chk("rst_col", int'(kif.key_column_out), 4'b1111);
        chk("rst_valid", int'(kif.key_valid), 0);
        chk_levels("rst", 0, 0, 0);

        rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("col_order_%0d", i), int'(kif.key_column_out),
                int'(~(4'b0001 << (i / 4)) & 4'hF));
            tick();
        end

        // Single press, then release
        wait_scan_start();
        key_v = 8;
        exp_q.push_back(5'd7);
        scans(5);
        chk_levels("press8", 7, 1, 0);
        key_v = 0;
        scans(3);
        chk_levels("rel8", 7, 0, 0);

        // Direct change without release
        key_v = 13;
        exp_q.push_back(5'd12);
        scans(4);
        chk_levels("press13", 12, 1, 0);
        key_v = 14;
        exp_q.push_back(5'd13);
        scans(4);
        chk_levels("press14", 13, 1, 0);
        key_v = 0;
        scans(3);
        chk_levels("rel14", 13, 0, 0);

        // Two keys, rollover lockout
        key_v = 21;
        scans(4);
        chk_levels("multi21", 13, 0, 1);
        key_v = 1;
        scans(4);
        chk_levels("multi_lock", 13, 0, 1);
        key_v = 0;
        scans(3);
        chk_levels("multi_rel", 13, 0, 0);
        key_v = 1;
        exp_q.push_back(5'd0);
        scans(4);
        chk_levels("press1", 0, 1, 0);
        key_v = 0;
        scans(3);

        // Bounce every scan
        p0 = n_pulses;
        for (int i = 0; i < 10; i++) begin
            key_v = (i % 2 == 0) ? 5 : 0;
            wait_scan_start();
        end
        key_v = 0;
        scans(3);
        chk("bounce_pulses", n_pulses, p0);
        chk_levels("bounce", 0, 0, 0);

        // Reset while key 20 is held
        key_v = 20;
        exp_q.push_back(5'd19);
        scans(4);
        chk_levels("press20", 19, 1, 0);
        rst = 1'b1;
        tick();
        chk("midrst_col", int'(kif.key_column_out), 4'b1111);
        chk("midrst_valid", int'(kif.key_valid), 0);
        chk_levels("midrst", 0, 0, 0);
        rst = 1'b0;
        exp_q.push_back(5'd19);
        p0 = n_pulses;
        tick();
        chk("post_rst_col", int'(kif.key_column_out), 4'b1110);
        repeat (20) tick();
        chk("no_early_pulse", n_pulses, p0);
        for (int i = 0; i < 60 && n_pulses == p0; i++) tick();
        chk("refire_pulse", n_pulses, p0 + 1);
        chk_levels("refire", 19, 1, 0);
        key_v = 0;
        scans(3);

        // Out-of-range key number
        p0 = n_pulses;
        key_v = 27;
        scans(4);
        chk("oor_pulses", n_pulses, p0);
        chk_levels("oor", 19, 0, 0);

        repeat (4) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
